// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package shift_pkg;

  // Width of the shift-amount field carried with every request.
  localparam int SHAMT_W = 6;

  // Operation codes. PASS/PASSW forward the operand unchanged.
  typedef enum logic [2:0] {
    OP_SLL   = 3'b000,
    OP_SRL   = 3'b001,
    OP_SRA   = 3'b010,
    OP_PASS  = 3'b011,
    OP_SLLW  = 3'b100,
    OP_SRLW  = 3'b101,
    OP_SRAW  = 3'b110,
    OP_PASSW = 3'b111
  } shift_op_e;

  // Level k is placed in stage floor(k*stages/levels). The first level of a
  // stage is therefore the smallest k with k*stages >= stage*levels.
  function automatic int stage_first_level(int stage, int stages, int levels);
    return (stage * levels + stages - 1) / stages;
  endfunction

  // Number of mux levels that end up in a given stage.
  function automatic int stage_level_count(int stage, int stages, int levels);
    return stage_first_level(stage + 1, stages, levels) -
           stage_first_level(stage, stages, levels);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the barrel shifter: a group of mux levels followed by
// the stage register. The last stage also applies the W-op sign extension so
// the output comes straight from a register.
module shift_stage
  import shift_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int FIRST = 0,
  parameter int COUNT = 1,
  parameter int TAG_W = 5,
  parameter bit LAST  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [XLEN-1:0]    data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  shift_op_e          op_i,
  input  logic               fill_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [XLEN-1:0]    data_o,
  output logic [SHAMT_W-1:0] shamt_o,
  output shift_op_e          op_o,
  output logic               fill_o,
  output logic [TAG_W-1:0]   tag_o
);

  logic               valid_q;
  logic [XLEN-1:0]    data_q;
  logic [XLEN-1:0]    data_d;
  logic [SHAMT_W-1:0] shamt_q;
  shift_op_e          op_q;
  logic               fill_q;
  logic [TAG_W-1:0]   tag_q;
  logic               isLeft;
  logic               isWOp;

  assign isLeft = (op_i == OP_SLL) || (op_i == OP_SLLW);
  assign isWOp  = (XLEN == 64) && ((op_i == OP_SLLW) || (op_i == OP_SRLW) || (op_i == OP_SRAW));

  // The stage can take a new entry when it is empty or its content moves on.
  assign ready_o = !valid_q || ready_i;

  // Apply this stage's shift levels; right shifts bring in the captured fill bit.
  always_comb begin
    data_d = data_i;
    for (int k = FIRST; k < FIRST + COUNT; k++) begin
      if (shamt_i[k]) begin
        if (isLeft) begin
          data_d = data_d << (1 << k);
        end else begin
          data_d = (data_d >> (1 << k)) | (fill_i ? ~({XLEN{1'b1}} >> (1 << k)) : '0);
        end
      end
    end
    if (LAST && isWOp) begin
      for (int j = 32; j < XLEN; j++) begin
        data_d[j] = data_d[31];
      end
    end
  end

  // Stage register: flush empties it, otherwise it loads whenever it may advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      op_q    <= OP_SLL;
      fill_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (ready_o) begin
        valid_q <= valid_i;
      end
      if (ready_o && valid_i && !flush_i) begin
        data_q  <= data_d;
        shamt_q <= shamt_i;
        op_q    <= op_i;
        fill_q  <= fill_i;
        tag_q   <= tag_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign op_o    = op_q;
  assign fill_o  = fill_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/shift_unit.sv
// Pipelined barrel shifter for the integer execute stage. Prepares the operand
// for W ops, picks the fill bit, then runs the shift levels through STAGES
// registered stages with a valid/ready handshake on both ends.
module shift_unit
  import shift_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [XLEN-1:0]    in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int LEVELS = $clog2(XLEN);

  shift_op_e          opIn;
  logic               isW;
  logic               isPass;
  logic [XLEN-1:0]    dataIn;
  logic [SHAMT_W-1:0] shamtIn;
  logic               fillIn;

  logic               validC [STAGES+1];
  logic               readyC [STAGES+1];
  logic [XLEN-1:0]    dataC  [STAGES+1];
  logic [SHAMT_W-1:0] shamtC [STAGES+1];
  shift_op_e          opC    [STAGES+1];
  logic               fillC  [STAGES+1];
  logic [TAG_W-1:0]   tagC   [STAGES+1];

  // Input pre-processing: effective shift amount, 32-bit operand extension for
  // W right shifts, and the fill bit for arithmetic shifts.
  always_comb begin
    opIn    = shift_op_e'(in_op);
    isW     = (XLEN == 64) && ((opIn == OP_SLLW) || (opIn == OP_SRLW) || (opIn == OP_SRAW));
    isPass  = (opIn == OP_PASS) || (opIn == OP_PASSW);
    dataIn  = in_data;
    shamtIn = '0;
    fillIn  = 1'b0;
    if (!isPass) begin
      if (isW) begin
        shamtIn = {1'b0, in_shamt[4:0]};
      end else begin
        shamtIn = in_shamt & SHAMT_W'((1 << LEVELS) - 1);
      end
    end
    if (isW && (opIn == OP_SRLW)) begin
      for (int j = 32; j < XLEN; j++) begin
        dataIn[j] = 1'b0;
      end
    end
    if (isW && (opIn == OP_SRAW)) begin
      for (int j = 32; j < XLEN; j++) begin
        dataIn[j] = in_data[31];
      end
    end
    if ((opIn == OP_SRA) || (opIn == OP_SRAW)) begin
      fillIn = isW ? in_data[31] : in_data[XLEN-1];
    end
  end

  assign validC[0]      = in_valid;
  assign dataC[0]       = dataIn;
  assign shamtC[0]      = shamtIn;
  assign opC[0]         = opIn;
  assign fillC[0]       = fillIn;
  assign tagC[0]        = in_tag;
  assign readyC[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : gStage
    localparam int FIRST = stage_first_level(i, STAGES, LEVELS);
    localparam int COUNT = stage_level_count(i, STAGES, LEVELS);

    shift_stage #(
      .XLEN (XLEN),
      .FIRST(FIRST),
      .COUNT(COUNT),
      .TAG_W(TAG_W),
      .LAST (i == STAGES - 1)
    ) uStage (
      .clk    (clk),
      .rst    (rst),
      .flush_i(flush),
      .valid_i(validC[i]),
      .ready_o(readyC[i]),
      .data_i (dataC[i]),
      .shamt_i(shamtC[i]),
      .op_i   (opC[i]),
      .fill_i (fillC[i]),
      .tag_i  (tagC[i]),
      .ready_i(readyC[i+1]),
      .valid_o(validC[i+1]),
      .data_o (dataC[i+1]),
      .shamt_o(shamtC[i+1]),
      .op_o   (opC[i+1]),
      .fill_o (fillC[i+1]),
      .tag_o  (tagC[i+1])
    );
  end

  assign in_ready  = readyC[0];
  assign out_valid = validC[STAGES];
  assign out_data  = dataC[STAGES];
  assign out_tag   = tagC[STAGES];

endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: several parameterisations share one stimulus stream.
// Configuration 0 (XLEN=64, STAGES=2) gets directed vectors and handshake
// sequences; every configuration is tracked by an in-order expected queue
// filled from an arithmetic reference model.
module tb_shift_unit;
  import shift_pkg::*;

  localparam int NCFG = 7;

  function automatic int cfgXlen(int k);
    return (k == 6) ? 32 : 64;
  endfunction

  function automatic int cfgStages(int k);
    case (k)
      0: return 2;
      1: return 1;
      2: return 3;
      3: return 4;
      4: return 5;
      5: return 6;
      default: return 5;
    endcase
  endfunction

  logic        clk;
  logic        rst;
  logic        inValid;
  logic [2:0]  inOp;
  logic [63:0] inData;
  logic [5:0]  inShamt;
  logic [4:0]  inTag;
  logic        flush;
  logic        outReady;

  logic        iReady [NCFG];
  logic        oValid [NCFG];
  logic [63:0] oData  [NCFG];
  logic [4:0]  oTag   [NCFG];

  int checks;
  int failures;

  logic [63:0] expData [NCFG][16];
  logic [4:0]  expTag  [NCFG][16];
  int          head    [NCFG];
  int          cnt     [NCFG];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < NCFG; k++) begin : gCfg
    localparam int XL = cfgXlen(k);
    localparam int ST = cfgStages(k);
    logic          rdy;
    logic          vld;
    logic [XL-1:0] dat;
    logic [4:0]    tg;

    shift_unit #(.XLEN(XL), .STAGES(ST), .TAG_W(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (inValid),
      .in_ready (rdy),
      .in_op    (inOp),
      .in_data  (inData[XL-1:0]),
      .in_shamt (inShamt),
      .in_tag   (inTag),
      .flush    (flush),
      .out_valid(vld),
      .out_ready(outReady),
      .out_data (dat),
      .out_tag  (tg)
    );

    assign iReady[k] = rdy;
    assign oValid[k] = vld;
    assign oData[k]  = 64'(dat);
    assign oTag[k]   = tg;
  end

  // Reference: the shift defined directly with shift operators on 32/64-bit values.
  function automatic logic [63:0] refShift(int xlen, logic [2:0] op, logic [63:0] d, logic [5:0] sh);
    logic [63:0]        r;
    logic [31:0]        lo;
    logic [31:0]        t;
    logic signed [31:0] slo;
    logic signed [63:0] sd;
    int                 s;
    lo  = d[31:0];
    slo = $signed(lo);
    sd  = $signed(d);
    r   = d;
    if (op[1:0] == 2'b11) begin
      r = d;
    end else if (xlen == 32) begin
      s = int'(sh[4:0]);
      case (op[1:0])
        2'b00:   t = lo << s;
        2'b01:   t = lo >> s;
        default: t = slo >>> s;
      endcase
      r = {32'd0, t};
    end else if (!op[2]) begin
      s = int'(sh);
      case (op[1:0])
        2'b00:   r = d << s;
        2'b01:   r = d >> s;
        default: r = sd >>> s;
      endcase
    end else begin
      s = int'(sh[4:0]);
      case (op[1:0])
        2'b00:   t = lo << s;
        2'b01:   t = lo >> s;
        default: t = slo >>> s;
      endcase
      r = {{32{t[31]}}, t};
    end
    if (xlen == 32) r[63:32] = 32'd0;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%h expected=0x%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [63:0] data,
                               input logic [5:0] shamt, input logic [4:0] tag);
    @(posedge clk);
    #1;
    inValid = 1'b1;
    inOp    = op;
    inData  = data;
    inShamt = shamt;
    inTag   = tag;
    flush   = 1'b0;
  endtask

  // Tracks every configuration: pops on output handshakes, pushes on accepts.
  task automatic monitorLoop();
    int idx;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NCFG; k++) begin
        if (rst) begin
          head[k] = 0;
          cnt[k]  = 0;
        end else begin
          if (oValid[k] && outReady) begin
            if (cnt[k] == 0) begin
              checkOutput($sformatf("cfg%0d spurious out_valid", k), 64'(oValid[k]), 64'd0);
            end else begin
              checkOutput($sformatf("cfg%0d out_data", k), oData[k], expData[k][head[k]]);
              checkOutput($sformatf("cfg%0d out_tag", k), 64'(oTag[k]), 64'(expTag[k][head[k]]));
              head[k] = (head[k] + 1) % 16;
              cnt[k]  = cnt[k] - 1;
            end
          end
          if (flush) begin
            cnt[k] = 0;
          end else if (inValid && iReady[k]) begin
            if (cnt[k] < 16) begin
              idx = (head[k] + cnt[k]) % 16;
              expData[k][idx] = refShift(cfgXlen(k), inOp, inData, inShamt);
              expTag[k][idx]  = inTag;
              cnt[k] = cnt[k] + 1;
            end
            checkOutput($sformatf("cfg%0d in-flight bound", k), 64'(cnt[k] <= cfgStages(k)), 64'd1);
          end
        end
      end
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [63:0] data;
    logic [5:0]  shamt;
    logic [63:0] expData;
  } vec_t;

  vec_t vecs [12];

  // Sends one vector to configuration 0 and checks result, tag and latency.
  task automatic runVector(input vec_t v, input int idx);
    bit ok;
    int lat;
    applyStimulus(v.op, v.data, v.shamt, 5'(idx + 1));
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (!ok) begin
        @(negedge clk);
        if (iReady[0]) ok = 1'b1;
        @(posedge clk);
      end
    end
    #1;
    inValid = 1'b0;
    if (!ok) begin
      checkOutput($sformatf("vec%0d accept timeout", idx), 64'd0, 64'd1);
    end else begin
      lat = 1;
      ok  = 1'b0;
      for (int n = 0; n < 20; n++) begin
        if (!ok) begin
          @(negedge clk);
          if (oValid[0]) begin
            ok = 1'b1;
          end else begin
            @(posedge clk);
            lat++;
          end
        end
      end
      if (!ok) begin
        checkOutput($sformatf("vec%0d result timeout", idx), 64'd0, 64'd1);
      end else begin
        checkOutput($sformatf("vec%0d data", idx), oData[0], v.expData);
        checkOutput($sformatf("vec%0d tag", idx), 64'(oTag[0]), 64'(idx + 1));
        checkOutput($sformatf("vec%0d latency", idx), 64'(lat), 64'd2);
      end
    end
  endtask

  initial begin
    int  acc;
    int  ngot;
    bit  lastReady;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    inValid  = 1'b0;
    inOp     = 3'd0;
    inData   = 64'd0;
    inShamt  = 6'd0;
    inTag    = 5'd0;
    flush    = 1'b0;
    outReady = 1'b1;
    for (int k = 0; k < NCFG; k++) begin
      head[k] = 0;
      cnt[k]  = 0;
    end

    vecs[0]  = '{3'b000, 64'h1,                   6'd63, 64'h8000_0000_0000_0000};
    vecs[1]  = '{3'b010, 64'h8000_0000_0000_0000, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{3'b001, 64'h8000_0000_0000_0000, 6'd63, 64'h1};
    vecs[3]  = '{3'b110, 64'h1234_5678_8000_0000, 6'd4,  64'hFFFF_FFFF_F800_0000};
    vecs[4]  = '{3'b100, 64'h1,                   6'd31, 64'hFFFF_FFFF_8000_0000};
    vecs[5]  = '{3'b101, 64'hFFFF_FFFF_8000_0000, 6'd33, 64'h0000_0000_4000_0000};
    vecs[6]  = '{3'b011, 64'h0123_4567_89AB_CDEF, 6'd5,  64'h0123_4567_89AB_CDEF};
    vecs[7]  = '{3'b111, 64'h0123_4567_89AB_CDEF, 6'd9,  64'h0123_4567_89AB_CDEF};
    vecs[8]  = '{3'b000, 64'hF0,                  6'd0,  64'hF0};
    vecs[9]  = '{3'b110, 64'hFFFF_FFFF_7000_0000, 6'd4,  64'h0000_0000_0700_0000};
    vecs[10] = '{3'b100, 64'h0000_0000_0001_0001, 6'd16, 64'h0000_0000_0001_0000};
    vecs[11] = '{3'b010, 64'h4000_0000_0000_0000, 6'd62, 64'h1};

    fork
      monitorLoop();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NCFG; k++) begin
      checkOutput($sformatf("cfg%0d reset out_valid", k), 64'(oValid[k]), 64'd0);
      checkOutput($sformatf("cfg%0d reset out_data", k), oData[k], 64'd0);
      checkOutput($sformatf("cfg%0d reset out_tag", k), 64'(oTag[k]), 64'd0);
      checkOutput($sformatf("cfg%0d reset in_ready", k), 64'(iReady[k]), 64'd1);
    end

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      runVector(vecs[i], i);
    end

    // Backpressure: four back-to-back ops with the consumer stalled
    acc = 0;
    ngot = 0;
    lastReady = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      outReady = 1'b0;
      inValid  = 1'b1;
      inOp     = 3'b000;
      inData   = 64'(acc + 1);
      inShamt  = 6'(acc + 1);
      inTag    = 5'(10 + acc);
      flush    = 1'b0;
      @(negedge clk);
      lastReady = iReady[0];
      if (iReady[0]) acc++;
      if (oValid[0]) begin
        checkOutput("bp held out_data", oData[0], 64'd2);
        checkOutput("bp held out_tag", 64'(oTag[0]), 64'd10);
      end
    end
    checkOutput("bp accepts before stall", 64'(acc), 64'd2);
    checkOutput("bp in_ready when full", 64'(lastReady), 64'd0);
    for (int c = 0; c < 40; c++) begin
      if (ngot < 4) begin
        @(posedge clk);
        #1;
        outReady = 1'b1;
        if (acc < 4) begin
          inValid = 1'b1;
          inData  = 64'(acc + 1);
          inShamt = 6'(acc + 1);
          inTag   = 5'(10 + acc);
        end else begin
          inValid = 1'b0;
        end
        @(negedge clk);
        if (oValid[0]) begin
          checkOutput("bp order tag", 64'(oTag[0]), 64'(10 + ngot));
          checkOutput("bp order data", oData[0], refShift(64, 3'b000, 64'(ngot + 1), 6'(ngot + 1)));
          ngot++;
        end
        if (inValid && iReady[0]) acc++;
      end
    end
    checkOutput("bp results delivered", 64'(ngot), 64'd4);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    repeat (10) @(posedge clk);

    // Flush with two ops in flight and a new request on the same cycle
    applyStimulus(3'b000, 64'h3, 6'd2, 5'd20);
    outReady = 1'b0;
    applyStimulus(3'b001, 64'hF00, 6'd4, 5'd21);
    applyStimulus(3'b010, 64'hF000_0000_0000_0000, 6'd8, 5'd22);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("flush out_valid", 64'(oValid[0]), 64'd0);
    end
    repeat (8) @(posedge clk);
    runVector(vecs[3], 3);

    // Asynchronous reset in the middle of traffic
    repeat (8) @(posedge clk);
    applyStimulus(3'b000, 64'h5, 6'd1, 5'd7);
    outReady = 1'b0;
    applyStimulus(3'b000, 64'h5, 6'd1, 5'd7);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    @(negedge clk);
    checkOutput("rst pre out_valid", 64'(oValid[0]), 64'd1);
    checkOutput("rst pre out_data", oData[0], 64'hA);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst async out_valid", 64'(oValid[0]), 64'd0);
    checkOutput("rst async out_data", oData[0], 64'd0);
    checkOutput("rst async out_tag", 64'(oTag[0]), 64'd0);
    checkOutput("rst async in_ready", 64'(iReady[0]), 64'd1);
    @(negedge clk);
    #2;
    rst      = 1'b0;
    outReady = 1'b1;
    runVector(vecs[0], 0);

    // Random traffic across every configuration
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      inValid  = ($urandom_range(3) != 0);
      inOp     = 3'($urandom_range(7));
      inData   = {$urandom, $urandom};
      inShamt  = 6'($urandom_range(63));
      inTag    = 5'($urandom_range(31));
      outReady = ($urandom_range(3) != 0);
      flush    = ($urandom_range(49) == 0);
    end
    @(posedge clk);
    #1;
    inValid  = 1'b0;
    flush    = 1'b0;
    outReady = 1'b1;
    repeat (20) @(negedge clk);
    for (int k = 0; k < NCFG; k++) begin
      checkOutput($sformatf("cfg%0d drained", k), 64'(cnt[k]), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
